// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: default widths,
// the control-unit opcodes that drive it, and the next-PC select decode.
package pc_seq_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 3;

  localparam logic [3:0] OP_JUMP = 4'h8;
  localparam logic [3:0] OP_REL  = 4'h9;
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_POP,
    SEL_UNDER,
    SEL_CALL,
    SEL_REL,
    SEL_JMP,
    SEL_INC
  } next_sel_e;

  // Priority: stall > return > call > relative > absolute > increment.
  function automatic next_sel_e decode_sel(input logic stall, input logic s_ret,
                                           input logic swe, input logic s_rel,
                                           input logic s_inc, input logic empty);
    if (stall)       return SEL_HOLD;
    else if (s_ret)  return empty ? SEL_UNDER : SEL_POP;
    else if (swe)    return SEL_CALL;
    else if (s_rel)  return SEL_REL;
    else if (!s_inc) return SEL_JMP;
    else             return SEL_INC;
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Control-unit side bundle of the sequencer: next-PC selects and jump
// fields in, registered PC and return-stack status out.
interface pc_seq_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 3
);
  logic             stall;
  logic             s_inc;
  logic             s_rel;
  logic             swe;
  logic             s_ret;
  logic [PC_W-1:0]  dir;
  logic [PC_W-1:0]  offset;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] depth;
  logic             overflow;
  logic             underflow;

  // Selects are level-sampled every rising edge; no valid/ready pairing,
  // stall is the only flow control and it freezes all sequencer state.
  modport master (
    output stall, s_inc, s_rel, swe, s_ret, dir, offset,
    input  pc, depth, overflow, underflow
  );

  modport slave (
    input  stall, s_inc, s_rel, swe, s_ret, dir, offset,
    output pc, depth, overflow, underflow
  );
endinterface

// File: rtl/pc_seq_ret_stack.sv
// DEPTH x PC_W return-address LIFO. Push is ignored when full, pop when
// empty, and pop wins if both are requested.
module ret_stack #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  din,
  output logic [PC_W-1:0]  top,
  output logic [CNT_W-1:0] depth,
  output logic             full,
  output logic             empty
);

  logic [PC_W-1:0]  r_mem [DEPTH];
  logic [CNT_W-1:0] r_depth;
  logic             w_do_pop;
  logic             w_do_push;

  assign full      = (r_depth == CNT_W'(DEPTH));
  assign empty     = (r_depth == '0);
  assign depth     = r_depth;
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && !pop && !full;

  // Entries are matched against occupancy rather than indexed, so the
  // occupancy width never has to equal the address width.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_depth == CNT_W'(i + 1)) top = r_mem[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_depth <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_pop) begin
      r_depth <= r_depth - CNT_W'(1);
    end else if (w_do_push) begin
      r_depth <= r_depth + CNT_W'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (r_depth == CNT_W'(i)) r_mem[i] <= din;
      end
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: registered PC, next-PC mux and adders, a
// nested-call return stack, and sticky overflow/underflow flags.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic  clock,
  input  logic  reset,
  pc_seq_if.slave bus
);

  logic [PC_W-1:0]  r_pc;
  logic             r_overflow;
  logic             r_underflow;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_top;
  logic [CNT_W-1:0] w_depth;
  logic             w_full;
  logic             w_empty;
  next_sel_e        w_sel;

  // PC_W-bit sums wrap modulo 2**PC_W, including the pushed return address.
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_sel    = decode_sel(bus.stall, bus.s_ret, bus.swe, bus.s_rel,
                               bus.s_inc, w_empty);

  ret_stack #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (w_sel == SEL_CALL),
    .pop   (w_sel == SEL_POP),
    .din   (w_pc_inc),
    .top   (w_top),
    .depth (w_depth),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (w_sel)
        SEL_POP:   r_pc <= w_top;
        SEL_UNDER: begin
          r_pc        <= w_pc_inc;
          r_underflow <= 1'b1;
        end
        SEL_CALL: begin
          r_pc <= bus.dir;
          if (w_full) r_overflow <= 1'b1;
        end
        SEL_REL:   r_pc <= r_pc + bus.offset;
        SEL_JMP:   r_pc <= bus.dir;
        SEL_INC:   r_pc <= w_pc_inc;
        default:   r_pc <= r_pc;
      endcase
    end
  end

  assign bus.pc        = r_pc;
  assign bus.depth     = w_depth;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: a table of per-cycle vectors plus hand-written call
// nesting, underflow and stall sequences, checked through an expected queue.
module tb_pc_seq;

  localparam int PC_W  = 10;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int W     = PC_W + CNT_W + 2;
  localparam int N_TBL = 24;

  typedef struct {
    logic             rst;
    logic             stall;
    logic             s_ret;
    logic             swe;
    logic             s_rel;
    logic             s_inc;
    logic [PC_W-1:0]  dir;
    logic [PC_W-1:0]  offset;
    logic [PC_W-1:0]  e_pc;
    logic [CNT_W-1:0] e_depth;
    logic             e_ov;
    logic             e_un;
  } vec_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic [W-1:0] exp_q[$];
  vec_t tbl[N_TBL];

  pc_seq_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus();

  pc_seq #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic st, input logic ret,
                              input logic swe, input logic rel, input logic inc,
                              input int dir, input int off, input int e_pc,
                              input int e_dep, input logic e_ov, input logic e_un);
    vec_t v;
    v.rst = rst; v.stall = st; v.s_ret = ret; v.swe = swe; v.s_rel = rel; v.s_inc = inc;
    v.dir = PC_W'(dir); v.offset = PC_W'(off);
    v.e_pc = PC_W'(e_pc); v.e_depth = CNT_W'(e_dep); v.e_ov = e_ov; v.e_un = e_un;
    return v;
  endfunction

  // scoreboard compare: one expected record per clocked step
  task automatic check(input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    act_v = {bus.pc, bus.depth, bus.overflow, bus.underflow};
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: no expected entry queued, got pc=%h depth=%0d ov=%b un=%b",
               tag, bus.pc, bus.depth, bus.overflow, bus.underflow);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v === exp_v) n_pass++;
      else
        $display("FAIL %s: got pc=%h depth=%0d ov=%b un=%b, want pc=%h depth=%0d ov=%b un=%b",
                 tag, bus.pc, bus.depth, bus.overflow, bus.underflow,
                 exp_v[W-1 -: PC_W], exp_v[CNT_W+1:2], exp_v[1], exp_v[0]);
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 after rising
  task automatic step(input vec_t v, input string tag);
    @(negedge clock);
    reset      = v.rst;
    bus.stall  = v.stall;
    bus.s_ret  = v.s_ret;
    bus.swe    = v.swe;
    bus.s_rel  = v.s_rel;
    bus.s_inc  = v.s_inc;
    bus.dir    = v.dir;
    bus.offset = v.offset;
    exp_q.push_back({v.e_pc, v.e_depth, v.e_ov, v.e_un});
    @(posedge clock);
    #1;
    check(tag);
  endtask

  function automatic vec_t idle(input int e_pc, input int e_dep, input logic ov, input logic un);
    return mk(0, 0, 0, 0, 0, 1, $urandom_range(1023), $urandom_range(1023), e_pc, e_dep, ov, un);
  endfunction

  function automatic vec_t call(input int dir, input int e_dep, input logic ov, input logic un);
    return mk(0, 0, 0, 1, 0, 0, dir, 0, dir, e_dep, ov, un);
  endfunction

  function automatic vec_t ret(input int e_pc, input int e_dep, input logic ov, input logic un);
    return mk(0, 0, 1, 0, 0, 1, 0, 0, e_pc, e_dep, ov, un);
  endfunction

  function automatic vec_t jmp(input int dir, input int e_dep, input logic ov, input logic un);
    return mk(0, 0, 0, 0, 0, 0, dir, 0, dir, e_dep, ov, un);
  endfunction

  function automatic vec_t rst_v();
    return mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus.stall = 0; bus.s_ret = 0; bus.swe = 0; bus.s_rel = 0; bus.s_inc = 1;
    bus.dir = '0; bus.offset = '0;

    // sequential run, reset restart, call/return, relative and wrap cases
    tbl[0]  = rst_v();
    tbl[1]  = idle(1, 0, 0, 0);
    tbl[2]  = idle(2, 0, 0, 0);
    tbl[3]  = idle(3, 0, 0, 0);
    tbl[4]  = idle(4, 0, 0, 0);
    tbl[5]  = idle(5, 0, 0, 0);
    tbl[6]  = rst_v();
    tbl[7]  = idle(1, 0, 0, 0);
    tbl[8]  = idle(2, 0, 0, 0);
    tbl[9]  = idle(3, 0, 0, 0);
    tbl[10] = call('h40, 1, 0, 0);
    tbl[11] = ret(4, 0, 0, 0);
    tbl[12] = idle(5, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 1, 1, 0, 'h3FE, 3, 0, 0, 0);
    tbl[14] = jmp('h3FF, 0, 0, 0);
    tbl[15] = idle(0, 0, 0, 0);
    tbl[16] = jmp('h3F0, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 1, 0, 'h155, 'h20, 'h010, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 1, 1, 0, 'h005, 'h015, 0, 0, 0);
    tbl[19] = jmp('h3FF, 0, 0, 0);
    tbl[20] = call('h100, 1, 0, 0);
    tbl[21] = ret('h000, 0, 0, 0);
    tbl[22] = mk(0, 0, 0, 1, 0, 1, 'h55, 0, 'h55, 1, 0, 0);
    tbl[23] = ret(1, 0, 0, 0);

    for (int i = 0; i < N_TBL; i++) step(tbl[i], $sformatf("tbl[%0d]", i));

    // five nested calls: fifth overflows, stack keeps the first four
    step(rst_v(), "nest_rst");
    step(idle(1, 0, 0, 0), "nest_pc1");
    step(call('h11, 1, 0, 0), "nest_call1");
    step(call('h21, 2, 0, 0), "nest_call2");
    step(call('h31, 3, 0, 0), "nest_call3");
    step(call('h41, 4, 0, 0), "nest_call4");
    step(call('h51, 4, 1, 0), "nest_call5_ovf");
    step(ret('h32, 3, 1, 0), "nest_ret1");
    step(ret('h22, 2, 1, 0), "nest_ret2");
    step(ret('h12, 1, 1, 0), "nest_ret3");
    step(ret('h02, 0, 1, 0), "nest_ret4");
    step(idle('h03, 0, 1, 0), "nest_ovf_sticky");

    // return on empty stack, flag sticks through later traffic
    step(rst_v(), "und_rst");
    step(jmp(7, 0, 0, 0), "und_jmp7");
    step(ret(8, 0, 0, 1), "und_ret");
    step(idle(9, 0, 0, 1), "und_idle");
    step(call('h20, 1, 0, 1), "und_call");
    step(ret('h0A, 0, 0, 1), "und_ret_ok");
    step(idle('h0B, 0, 0, 1), "und_sticky");

    // stall freezes everything; simultaneous swe+s_ret pops only
    step(rst_v(), "stl_rst");
    step(jmp('h10, 0, 0, 0), "stl_jmp");
    step(call('h30, 1, 0, 0), "stl_call");
    step(mk(0, 1, 0, 1, 0, 0, 'h99, 0, 'h30, 1, 0, 0), "stl_swe");
    step(mk(0, 1, 1, 0, 0, 1, 'h99, 0, 'h30, 1, 0, 0), "stl_ret");
    step(mk(0, 0, 1, 1, 0, 0, 'h99, 0, 'h11, 0, 0, 0), "both_pop");
    step(ret('h12, 0, 0, 1), "both_then_under");
    step(mk(1, 1, 0, 1, 0, 0, 'h99, 0, 0, 0, 0, 0), "rst_over_stall");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
